seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//  Parametrised, run-time programmable serial sequence detector; successor to the fixed 1010 Moore detector.
//  Pattern (up to PAT_W bits) and active length are loaded through a config port.
//  Overlapping and non-overlapping detection are selectable per cycle.
//  Output is registered (Moore-style); sits between a serial bit source and event/interrupt logic.
// PARAMETERS
//  PAT_W   4  maximum pattern length in bits (>=2)
//  CNT_W   8  width of match counter (SEQ_DET_COUNT_EN builds only)
//  LEN_W   $clog2(PAT_W+1)  width of cfg_len (localparam, not overridable)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous, active-low reset
//  in_valid     in   1      x is sampled only on edges where in_valid=1
//  x            in   1      serial input bit
//  mode_ovl     in   1      1 = overlapping detection, 0 = non-overlapping
//  cfg_load     in   1      latch cfg_pattern/cfg_len; clears detection history
//  cfg_pattern  in   PAT_W  pattern; bit [len-1] is the first bit received, bit [0] the last
//  cfg_len      in   LEN_W  active pattern length; 0 or >PAT_W is clamped to PAT_W
//  z            out  1      registered match pulse, one cycle per match
//  match_cnt    out  CNT_W  saturating match count (SEQ_DET_COUNT_EN only)
// BEHAVIOUR
//  Reset (rst_n=0, async)
//   - hist=0, fill=0, z=0, match_cnt=0.
//   - pattern register = {PAT_W{1'b0}} | 4'b1010 truncated/zero-extended; len = PAT_W.
//  State
//   - hist[PAT_W-1:0]: shift register, newest bit at [0].
//   - fill: 0..PAT_W, count of valid bits since last clear.
//  Accepted bit (in_valid=1, cfg_load=0)
//   - hist <= {hist[PAT_W-2:0], x}; fill <= min(fill+1, PAT_W).
//  Match condition (combinational on next-state values)
//   - hist_next[len-1:0] == pattern[len-1:0] AND fill_next >= len.
//  Output timing
//   - z <= match: z is high the cycle after the edge that sampled the final pattern bit.
//   - z is 0 on any edge without an accepted bit, so a match always produces a 1-cycle pulse.
//  Overlap mode (mode_ovl=1)
//   - fill is not cleared on a match; suffix bits count toward the next match.
//  Non-overlap mode (mode_ovl=0)
//   - On a match, fill <= 0 (hist still shifts); the next match needs len fresh bits.
//   - mode_ovl is sampled on the match edge only.
//  Config load (cfg_load=1)
//   - pattern/len latched; fill <= 0; z <= 0; x is ignored that edge (cfg_load beats in_valid).
//   - Matches never span a reconfiguration.
//  in_valid=0
//   - hist/fill hold; a bubble does not break a partial sequence.
//  Reset mid-sequence
//   - All partial progress is lost; outputs return to reset values immediately.
// CONFIGURATION
//  SEQ_DET_COUNT_EN defined
//   - match_cnt increments on every edge that sets z=1, saturates at 2^CNT_W-1.
//   - Cleared by rst_n only; cfg_load does not clear it.
//  SEQ_DET_COUNT_EN undefined
//   - match_cnt port and counter logic are absent; z behaviour is identical.
// STRUCTURE
//  Package seq_det_pkg
//   - Default reset pattern constant.
//   - Length clamp function: returns the effective len from cfg_len and PAT_W.
//  Sub-module seq_det_sat_cnt
//   - Parametrised saturating counter: en, clk, rst_n, q.
//   - Instantiated under SEQ_DET_COUNT_EN only.
// TESTING
//  1. PAT_W=4, load 1010/len4, mode_ovl=1, stream 1,0,1,0,1,0
//     -> z pulses after bits 4 and 6; match_cnt=2.
//  2. Same stream plus 1,0 with mode_ovl=0
//     -> z pulses after bits 4 and 8 only; no pulse after bit 6.
//  3. Stream 1,0,[in_valid=0 x3],1,0
//     -> single z pulse after last bit; z stays 0 during bubbles.
//  4. After bits 1,0,1, assert rst_n=0 for 1 cycle, then send 0
//     -> no match. Then send 1,0,1,0 -> match after 4th bit.
//  5. Load 0110/len=3 (pattern 110), stream 1,1,0,1,1,0
//     -> z after bits 3 and 6. cfg_load issued mid-sequence -> prior bits ignored.
//  6. CNT_W=2, overlap, 1010 pattern, 10 repetitions of "10"
//     -> match_cnt saturates at 3 and holds.

Source files
------------

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and helpers for the programmable sequence detector.
//  RST_PAT   - pattern loaded at reset (the legacy 1010 detector's pattern)
//  clamp_len - maps a requested pattern length onto the usable range 1..pat_w
package seq_det_pkg;

  localparam logic [3:0] RST_PAT = 4'b1010;

  // A length of 0, or one longer than the hardware holds, means "use the full width".
  function automatic int clamp_len(input int len, input int pat_w);
    return (len == 0 || len > pat_w) ? pat_w : len;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// seq_det_sat_cnt: saturating up-counter.
//  clk   in   rising-edge clock
//  rst_n in   asynchronous active-low reset, clears q
//  en    in   increment request
//  q     out  count, sticks at all-ones
module seq_det_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                q <= '0;
    else if (en && (q != '1)) q <= q + 1'b1;
  end

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time programmable serial sequence detector, Moore-style
// registered match pulse, overlapping or non-overlapping detection.
// Optional feature macro: SEQ_DET_COUNT_EN adds a saturating match counter.
//  clk         in   rising-edge clock
//  rst_n       in   asynchronous active-low reset
//  in_valid    in   x is sampled only when high
//  x           in   serial input bit
//  mode_ovl    in   1 = overlapping, 0 = non-overlapping detection
//  cfg_load    in   latch cfg_pattern/cfg_len, clear detection history
//  cfg_pattern in   pattern, bit [len-1] received first, bit [0] last
//  cfg_len     in   active length, 0 or >PAT_W means PAT_W
//  z           out  one-cycle match pulse
//  match_cnt   out  saturating match count (SEQ_DET_COUNT_EN only)
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter  int PAT_W = 4,
`ifdef SEQ_DET_COUNT_EN
  parameter  int CNT_W = 8,
`endif
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             x,
  input  logic             mode_ovl,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
`ifdef SEQ_DET_COUNT_EN
  output logic [CNT_W-1:0] match_cnt,
`endif
  output logic             z
);

  logic [PAT_W-1:0] r_hist, r_pat, w_hist_nxt, w_mask;
  logic [LEN_W-1:0] r_fill, r_len, w_fill_nxt;
  logic             r_z, w_acc, w_match;

  // Config load takes priority over a valid bit on the same edge.
  assign w_acc = in_valid & ~cfg_load;

  always_comb begin
    w_hist_nxt = {r_hist[PAT_W-2:0], x};
    w_fill_nxt = (r_fill == LEN_W'(PAT_W)) ? r_fill : r_fill + 1'b1;
    // Only the low r_len bits of history take part in the compare.
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) w_mask[i] = (i < int'(r_len));
    w_match = w_acc && (((w_hist_nxt ^ r_pat) & w_mask) == '0) && (w_fill_nxt >= r_len);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
      r_z    <= 1'b0;
      r_pat  <= PAT_W'(RST_PAT);
      r_len  <= LEN_W'(PAT_W);
    end else if (cfg_load) begin
      r_pat  <= cfg_pattern;
      r_len  <= LEN_W'(clamp_len(int'(cfg_len), PAT_W));
      r_fill <= '0;
      r_z    <= 1'b0;
    end else if (w_acc) begin
      r_hist <= w_hist_nxt;
      // Non-overlap: a match consumes its bits, the next one needs len fresh bits.
      r_fill <= (w_match && !mode_ovl) ? '0 : w_fill_nxt;
      r_z    <= w_match;
    end else begin
      r_z    <= 1'b0;
    end
  end

  assign z = r_z;

`ifdef SEQ_DET_COUNT_EN
  seq_det_sat_cnt #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (w_match),
    .q     (match_cnt)
  );
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  localparam int PAT_W = 4;
  localparam int LEN_W = $clog2(PAT_W + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0, x = 1'b0, mode_ovl = 1'b1, cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             z;
`ifdef SEQ_DET_COUNT_EN
  logic [1:0]       match_cnt;
`endif

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  seq_detector_param #(
    .PAT_W(PAT_W)
`ifdef SEQ_DET_COUNT_EN
   ,.CNT_W(2)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .x           (x),
    .mode_ovl    (mode_ovl),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
`ifdef SEQ_DET_COUNT_EN
    .match_cnt   (match_cnt),
`endif
    .z           (z)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read there too.
  task automatic step(input logic v, input logic b);
    in_valid = v;
    x        = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // n cycles, vectors written first-bit-at-MSB; zs[i] is z after that cycle.
  task automatic run(input string tag, input int n, input logic [31:0] xs,
                     input logic [31:0] vs, input logic [31:0] zs);
    for (int i = n - 1; i >= 0; i--) begin
      step(vs[i], xs[i]);
      chk($sformatf("%s.z%0d", tag, n - 1 - i), {31'b0, z}, {31'b0, zs[i]});
    end
  endtask

  // x/in_valid held high during the load to show cfg_load wins.
  task automatic load(input string tag, input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l);
    cfg_load = 1'b1; cfg_pattern = p; cfg_len = l;
    in_valid = 1'b1; x = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0; in_valid = 1'b0;
    chk({tag, ".ldz"}, {31'b0, z}, 32'd0);
  endtask

  initial begin
    #2;
    chk("rst.z", {31'b0, z}, 32'd0);
`ifdef SEQ_DET_COUNT_EN
    chk("rst.cnt", {30'b0, match_cnt}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset pattern 1010/len4, overlapping: matches after bits 4 and 6.
    mode_ovl = 1'b1;
    run("t1", 6, 6'b101010, 6'b111111, 6'b000101);
`ifdef SEQ_DET_COUNT_EN
    chk("t1.cnt", {30'b0, match_cnt}, 32'd2);
`endif

    // Non-overlapping: bit 6 does not match, bit 8 does.
    load("t2", 4'b1010, 3'd4);
    mode_ovl = 1'b0;
    run("t2", 8, 8'b10101010, 8'hFF, 8'b00010001);

    // Bubbles hold partial progress.
    load("t3", 4'b1010, 3'd4);
    mode_ovl = 1'b1;
    run("t3", 7, 7'b1000010, 7'b1100011, 7'b0000001);

    // Reset mid-sequence discards partial 1,0,1.
    load("t4", 4'b1010, 3'd4);
    run("t4a", 3, 3'b101, 3'b111, 3'b000);
    rst_n = 1'b0;
    #1;
    chk("t4.rstz", {31'b0, z}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run("t4b", 5, 5'b01010, 5'b11111, 5'b00001);

    // Length-3 pattern 110.
    load("t5", 4'b0110, 3'd3);
    run("t5a", 6, 6'b110110, 6'b111111, 6'b001001);
    // Reload mid-sequence: the earlier 1,1 must not combine with the next 0.
    run("t5b", 2, 2'b11, 2'b11, 2'b00);
    load("t5", 4'b0110, 3'd3);
    run("t5c", 4, 4'b0110, 4'b1111, 4'b0001);

    // Length clamps and single-bit patterns.
    load("t6a", 4'b1010, 3'd0);
    run("t6a", 4, 4'b1010, 4'b1111, 4'b0001);
    load("t6b", 4'b0001, 3'd1);
    run("t6b", 4, 4'b1101, 4'b1111, 4'b1101);
    mode_ovl = 1'b0;
    run("t6c", 4, 4'b1101, 4'b1111, 4'b1101);
    mode_ovl = 1'b1;
    load("t6d", 4'b1010, 3'd7);
    run("t6d", 5, 5'b01010, 5'b11111, 5'b00001);

`ifdef SEQ_DET_COUNT_EN
    // Nine matches into a 2-bit counter: saturates at 3; reload keeps the count.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
    end
    chk("t7.cnt", {30'b0, match_cnt}, 32'd3);
    load("t7", 4'b1010, 3'd4);
    chk("t7.cntld", {30'b0, match_cnt}, 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
